// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch input conditioner: FSM state encoding and
// default parameter values.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE_S  = 2'd1,
    DRIVE_R  = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned PULSE_CYCLES_DEF    = 2;

endpackage

// File: rtl/debounce_filter.sv
// One push-button channel: synchroniser, debounce counter, filtered level and a
// registered one-cycle press pulse on the filtered 0->1 transition.
module debounce_filter
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   level_d;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Any cycle agreeing with the filtered level restarts the qualification count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_input_conditioner.sv
// Conditions two raw buttons into clean, mutually exclusive S/R drive windows
// with Enable, plus the latch's active-low Clear.
module sr_input_conditioner
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Set_btn,
  input  logic Reset_btn,
  output logic S,
  output logic R,
  output logic Enable,
  output logic Clear,
  output logic Busy,
  output logic Conflict
);

  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

  logic   level_s, level_r;
  logic   press_s, press_r;
  state_t state, state_next;
  logic [PW-1:0] pcnt, pcnt_next;
  logic   conflict_next;

  debounce_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set_filter (
    .clk  (Clock),
    .rst  (Reset),
    .raw  (Set_btn),
    .level(level_s),
    .press(press_s)
  );

  debounce_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_reset_filter (
    .clk  (Clock),
    .rst  (Reset),
    .raw  (Reset_btn),
    .level(level_r),
    .press(press_r)
  );

  // Reset request wins a tie; presses outside IDLE are simply dropped.
  always_comb begin
    state_next    = state;
    pcnt_next     = pcnt;
    conflict_next = 1'b0;
    case (state)
      IDLE: begin
        pcnt_next = '0;
        if (press_r) begin
          state_next    = DRIVE_R;
          conflict_next = press_s;
        end else if (press_s) begin
          state_next = DRIVE_S;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (pcnt == PULSE_LAST) begin
          state_next = WAIT_REL;
          pcnt_next  = '0;
        end else begin
          pcnt_next = pcnt + PW'(1);
        end
      end
      WAIT_REL: begin
        if (!level_s && !level_r) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      pcnt     <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      Enable   <= 1'b0;
      Busy     <= 1'b0;
      Conflict <= 1'b0;
      Clear    <= 1'b0;
    end else begin
      state    <= state_next;
      pcnt     <= pcnt_next;
      S        <= (state_next == DRIVE_S);
      R        <= (state_next == DRIVE_R);
      Enable   <= (state_next == DRIVE_S) || (state_next == DRIVE_R);
      Busy     <= (state_next != IDLE);
      Conflict <= conflict_next;
      Clear    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Directed bench for sr_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// PULSE_CYCLES=2; outputs compared as {S,R,Enable,Clear,Busy,Conflict}.
module tb_sr_input_conditioner;

  logic Clock, Reset, Set_btn, Reset_btn;
  logic S, R, Enable, Clear, Busy, Conflict;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] O_RST  = 6'b000000;
  localparam logic [5:0] O_IDLE = 6'b000100;
  localparam logic [5:0] O_WAIT = 6'b000110;
  localparam logic [5:0] O_S    = 6'b101110;
  localparam logic [5:0] O_R    = 6'b011110;
  localparam logic [5:0] O_RC   = 6'b011111;

  sr_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (2)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Set_btn  (Set_btn),
    .Reset_btn(Reset_btn),
    .S        (S),
    .R        (R),
    .Enable   (Enable),
    .Clear    (Clear),
    .Busy     (Busy),
    .Conflict (Conflict)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {S, R, Enable, Clear, Busy, Conflict};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed SREnClrBusyConf=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected outputs t ticks after the qualifying input first gets sampled clean,
  // for a window starting at tick 'start'.
  function automatic logic [5:0] window(int t, int start, logic [5:0] first, logic [5:0] second);
    if (t < start) return O_IDLE;
    if (t == start) return first;
    if (t == start + 1) return second;
    return O_WAIT;
  endfunction

  // Drop both buttons; Busy must fall exactly 7 ticks later.
  task automatic release_all(input string tag);
    Set_btn   = 1'b0;
    Reset_btn = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk($sformatf("%s_rel_t%0d", tag, t), (t < 7) ? O_WAIT : O_IDLE);
    end
    tick();
    chk($sformatf("%s_idle", tag), O_IDLE);
  endtask

  logic [4:0] bounce;

  initial begin
    Reset     = 1'b1;
    Set_btn   = 1'b0;
    Reset_btn = 1'b0;

    // Reset held for three cycles, then released
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk($sformatf("reset_t%0d", t), O_RST);
    end
    Reset = 1'b0;
    tick();
    chk("clear_rises", O_IDLE);
    tick();
    chk("idle_after_reset", O_IDLE);

    // Clean set press held 20 cycles
    Set_btn = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      chk($sformatf("clean_t%0d", t), window(t, 8, O_S, O_S));
    end
    release_all("clean");

    // Bouncy set press: 1,0,1,1,0 then steady high
    bounce = 5'b01101;
    for (int t = 1; t <= 22; t++) begin
      Set_btn = (t <= 5) ? bounce[t-1] : 1'b1;
      tick();
      chk($sformatf("bounce_t%0d", t), window(t, 13, O_S, O_S));
    end
    release_all("bounce");

    // Both buttons rise together
    Set_btn   = 1'b1;
    Reset_btn = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("simul_t%0d", t), window(t, 8, O_RC, O_R));
    end
    release_all("simul");

    // Reset press qualifying during DRIVE_S and again in WAIT_REL is discarded
    Set_btn = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      Reset_btn = 1'b1;
      chk($sformatf("ignored_t%0d", t), window(t, 8, O_S, O_S));
    end
    release_all("ignored");

    // Fresh reset press after release
    Reset_btn = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("fresh_r_t%0d", t), window(t, 8, O_R, O_R));
    end
    release_all("fresh_r");

    // Reset asserted in the first DRIVE_S cycle while Set_btn stays held
    Set_btn = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
    end
    chk("middrive_first_s", O_S);
    Reset = 1'b1;
    tick();
    chk("middrive_reset", O_RST);
    Reset = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk($sformatf("requal_t%0d", t), window(t, 8, O_S, O_S));
    end
    release_all("requal");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
